mem_arbiter: RTL and testbench

Shares one unified `mem` instance between instruction fetch and the load/store path, replacing the separate imem/dmem pair when the core moves to a single memory. Arbitrates one access at a time, holds the memory port stable for a parameterised latency, and returns read data or write completion to the winning requester. Sits between `fetch`/the load-store datapath and `mem`.

---
 rtl/mem_arbiter_pkg.sv | 43 ++++
 rtl/mem_arb_select.sv | 35 +++
 rtl/mem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// Provides the FSM state and requester ID enums, the mem access-size
// encodings, and the mem port payload struct with its idle value.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 2;
  localparam int unsigned CNT_W  = 4;

  localparam logic [SIZE_W-1:0] ACCESS_SIZE_BYTE = 2'd0;
  localparam logic [SIZE_W-1:0] ACCESS_SIZE_HALF = 2'd1;
  localparam logic [SIZE_W-1:0] ACCESS_SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    SRC_FETCH = 1'b0,
    SRC_DATA  = 1'b1
  } arb_src_t;

  // Everything the arbiter drives toward mem during an access.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              read_write;
    logic [SIZE_W-1:0] access_size;
    logic              unsigned_access;
  } mem_port_t;

  localparam mem_port_t MEM_PORT_IDLE = '{
    addr:            '0,
    data:            '0,
    read_write:      1'b1,
    access_size:     ACCESS_SIZE_WORD,
    unsigned_access: 1'b1
  };

endpackage

// File: rtl/mem_arb_select.sv
// Combinational winner selection between fetch and data requesters.
// Ports:
//   arb_en       in   arbitration window open (FSM in IDLE or RESP)
//   setup_write  in   test-setup write in progress, suppresses grants
//   if_req/d_req in   requests from fetch and load/store path
//   wait_cnt     in   consecutive arbitrations fetch has lost
//   grant_c      out  a grant happens at the coming edge
//   fetch_wins_c out  winner is fetch (else data); meaningful with grant_c
module mem_arb_select
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic             arb_en,
  input  logic             setup_write,
  input  logic             if_req,
  input  logic             d_req,
  input  logic [CNT_W-1:0] wait_cnt,
  output logic             grant_c,
  output logic             fetch_wins_c
);

  // Data has priority; fetch overrides it once it has starved long enough.
  always_comb begin
    grant_c      = 1'b0;
    fetch_wins_c = 1'b0;
    if (arb_en && !setup_write && (if_req || d_req)) begin
      grant_c = 1'b1;
      if (!d_req || (if_req && (wait_cnt >= CNT_W'(MAX_WAIT)))) begin
        fetch_wins_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one unified mem between instruction fetch and load/store.
// One access at a time: the winner's fields are latched into the mem port
// registers for MEM_LATENCY cycles, then read data (or 0 for stores) is
// returned with a one-cycle rvalid pulse to the winner.
// Ports:
//   clock, reset (sync, active-low)
//   if_req/if_addr -> if_gnt/if_rvalid/if_rdata     fetch side
//   d_req/d_addr/d_wdata/d_read_write/d_access_size/d_unsigned
//                  -> d_gnt/d_rvalid/d_rdata          load/store side
//   mem_address/mem_data_in/mem_read_write/mem_access_size/
//   mem_unsigned_access out, mem_data_out in          unified mem port
//   setup_write in blocks new grants; busy out high while in ACCESS
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned MAX_WAIT    = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_read_write,
  input  logic [1:0]  d_access_size,
  input  logic        d_unsigned,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_read_write,
  output logic [1:0]  mem_access_size,
  output logic        mem_unsigned_access,
  input  logic [31:0] mem_data_out,
  input  logic        setup_write,
  output logic        busy
);

  arb_state_t        state_q, state_d;
  arb_src_t          src_q, src_d;
  mem_port_t         port_q, port_d;
  logic [CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              if_gnt_q, if_gnt_d;
  logic              d_gnt_q, d_gnt_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              busy_q, busy_d;

  logic grant_c;
  logic fetch_wins_c;

  mem_arb_select #(
    .MAX_WAIT(MAX_WAIT)
  ) u_select (
    .arb_en      (state_q != ACCESS),
    .setup_write (setup_write),
    .if_req      (if_req),
    .d_req       (d_req),
    .wait_cnt    (wait_cnt_q),
    .grant_c     (grant_c),
    .fetch_wins_c(fetch_wins_c)
  );

  // Next state, port latching, response capture and starvation counter.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    port_d      = port_q;
    lat_cnt_d   = lat_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = '0;
    d_rdata_d   = '0;

    if (state_q == ACCESS) begin
      if (lat_cnt_q == CNT_W'(1)) begin
        state_d = RESP;
        port_d  = MEM_PORT_IDLE;
        if (src_q == SRC_FETCH) begin
          if_rvalid_d = 1'b1;
          if_rdata_d  = mem_data_out;
        end else begin
          d_rvalid_d = 1'b1;
          // Stores complete with zero data.
          d_rdata_d  = port_q.read_write ? mem_data_out : '0;
        end
      end else begin
        lat_cnt_d = lat_cnt_q - CNT_W'(1);
      end
    end else if (grant_c) begin
      state_d   = ACCESS;
      lat_cnt_d = CNT_W'(MEM_LATENCY);
      if (fetch_wins_c) begin
        src_d    = SRC_FETCH;
        if_gnt_d = 1'b1;
        port_d   = '{addr:            if_addr,
                     data:            '0,
                     read_write:      1'b1,
                     access_size:     ACCESS_SIZE_WORD,
                     unsigned_access: 1'b1};
      end else begin
        src_d   = SRC_DATA;
        d_gnt_d = 1'b1;
        port_d  = '{addr:            d_addr,
                    data:            d_wdata,
                    read_write:      d_read_write,
                    access_size:     d_access_size,
                    unsigned_access: d_unsigned};
      end
    end else begin
      state_d = IDLE;
    end

    // Starvation counter freezes while a setup write owns the memory.
    if (!setup_write) begin
      if (!if_req || (grant_c && fetch_wins_c)) begin
        wait_cnt_d = '0;
      end else if (grant_c && (wait_cnt_q != '1)) begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
    end

    busy_d = (state_d == ACCESS);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      src_q       <= SRC_FETCH;
      port_q      <= MEM_PORT_IDLE;
      lat_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      port_q      <= port_d;
      lat_cnt_q   <= lat_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign if_gnt              = if_gnt_q;
  assign if_rvalid           = if_rvalid_q;
  assign if_rdata            = if_rdata_q;
  assign d_gnt               = d_gnt_q;
  assign d_rvalid            = d_rvalid_q;
  assign d_rdata             = d_rdata_q;
  assign mem_address         = port_q.addr;
  assign mem_data_in         = port_q.data;
  assign mem_read_write      = port_q.read_write;
  assign mem_access_size     = port_q.access_size;
  assign mem_unsigned_access = port_q.unsigned_access;
  assign busy                = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: u0 runs MEM_LATENCY=1, u1 MEM_LATENCY=3.
module tb_mem_arbiter;

  typedef struct {
    int          inst;
    logic        is_data;
    logic [31:0] data;
  } exp_t;

  exp_t gnt_q[$];
  exp_t rsp_q[$];
  int   vec  = 0;
  int   miss = 0;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic setup_write = 1'b0;

  // instance 0 (latency 1)
  logic        if_req0 = 1'b0, d_req0 = 1'b0, d_rw0 = 1'b1, d_uns0 = 1'b0;
  logic [31:0] if_addr0 = '0, d_addr0 = '0, d_wdata0 = '0;
  logic [1:0]  d_size0 = 2'd2;
  logic        if_gnt0, if_rvalid0, d_gnt0, d_rvalid0, mrw0, muns0, busy0;
  logic [31:0] if_rdata0, d_rdata0, maddr0, mdin0, mdo0;
  logic [1:0]  msize0;

  // instance 1 (latency 3)
  logic        if_req1 = 1'b0, d_req1 = 1'b0, d_rw1 = 1'b1, d_uns1 = 1'b0;
  logic [31:0] if_addr1 = '0, d_addr1 = '0, d_wdata1 = '0;
  logic [1:0]  d_size1 = 2'd2;
  logic        if_gnt1, if_rvalid1, d_gnt1, d_rvalid1, mrw1, muns1, busy1;
  logic [31:0] if_rdata1, d_rdata1, maddr1, mdin1, mdo1;
  logic [1:0]  msize1;

  always #5 clock = ~clock;

  // Memory contents seen by both instances.
  function automatic logic [31:0] lookup(input logic [31:0] a);
    case (a)
      32'h0000_0100: lookup = 32'h0000_0013;
      32'h0000_0203: lookup = 32'h0000_00AB;
      default:       lookup = a ^ 32'h5A5A_0000;
    endcase
  endfunction

  assign mdo0 = lookup(maddr0);
  assign mdo1 = lookup(maddr1);

  mem_arbiter #(.MEM_LATENCY(1), .MAX_WAIT(4)) u0 (
    .clock(clock), .reset(reset),
    .if_req(if_req0), .if_addr(if_addr0), .if_gnt(if_gnt0),
    .if_rvalid(if_rvalid0), .if_rdata(if_rdata0),
    .d_req(d_req0), .d_addr(d_addr0), .d_wdata(d_wdata0),
    .d_read_write(d_rw0), .d_access_size(d_size0), .d_unsigned(d_uns0),
    .d_gnt(d_gnt0), .d_rvalid(d_rvalid0), .d_rdata(d_rdata0),
    .mem_address(maddr0), .mem_data_in(mdin0), .mem_read_write(mrw0),
    .mem_access_size(msize0), .mem_unsigned_access(muns0),
    .mem_data_out(mdo0), .setup_write(setup_write), .busy(busy0)
  );

  mem_arbiter #(.MEM_LATENCY(3), .MAX_WAIT(4)) u1 (
    .clock(clock), .reset(reset),
    .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1),
    .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .d_req(d_req1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_read_write(d_rw1), .d_access_size(d_size1), .d_unsigned(d_uns1),
    .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .mem_address(maddr1), .mem_data_in(mdin1), .mem_read_write(mrw1),
    .mem_access_size(msize1), .mem_unsigned_access(muns1),
    .mem_data_out(mdo1), .setup_write(1'b0), .busy(busy1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_g(input int inst, input logic is_data);
    exp_t e;
    e.inst = inst; e.is_data = is_data; e.data = '0;
    gnt_q.push_back(e);
  endtask

  task automatic push_r(input int inst, input logic is_data, input logic [31:0] data);
    exp_t e;
    e.inst = inst; e.is_data = is_data; e.data = data;
    rsp_q.push_back(e);
  endtask

  // Pops one expected grant/response per observed pulse.
  task automatic observe(input int inst, input logic ig, input logic dg,
                         input logic iv, input logic dv,
                         input logic [31:0] ir, input logic [31:0] dr);
    exp_t e;
    if (ig === 1'b1 || dg === 1'b1) begin
      vec++;
      if (ig === 1'b1 && dg === 1'b1) begin
        miss++;
        $display("FAIL dual_gnt u%0d: both grants high, expected one", inst);
      end else if (gnt_q.size() == 0) begin
        miss++;
        $display("FAIL unexpected_gnt u%0d: got %s grant, expected none", inst, dg ? "data" : "fetch");
      end else begin
        e = gnt_q.pop_front();
        if (e.inst != inst || e.is_data !== dg) begin
          miss++;
          $display("FAIL gnt_order: got u%0d is_data=%0b, expected u%0d is_data=%0b",
                   inst, dg, e.inst, e.is_data);
        end
      end
    end
    if (iv === 1'b1 || dv === 1'b1) begin
      vec++;
      if (iv === 1'b1 && dv === 1'b1) begin
        miss++;
        $display("FAIL dual_rvalid u%0d: both rvalids high, expected one", inst);
      end else if (rsp_q.size() == 0) begin
        miss++;
        $display("FAIL unexpected_rvalid u%0d: got %s rvalid, expected none", inst, dv ? "data" : "fetch");
      end else begin
        e = rsp_q.pop_front();
        if (e.inst != inst || e.is_data !== dv || e.data !== (dv ? dr : ir)) begin
          miss++;
          $display("FAIL rsp: got u%0d is_data=%0b data=%h, expected u%0d is_data=%0b data=%h",
                   inst, dv, dv ? dr : ir, e.inst, e.is_data, e.data);
        end
      end
    end
  endtask

  always @(negedge clock) begin
    observe(0, if_gnt0, d_gnt0, if_rvalid0, d_rvalid0, if_rdata0, d_rdata0);
    observe(1, if_gnt1, d_gnt1, if_rvalid1, d_rvalid1, if_rdata1, d_rdata1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    // Reset state
    tick(2);
    @(negedge clock);
    chk("rst_busy", 32'(busy0), 32'h0);
    chk("rst_addr", maddr0, 32'h0);
    chk("rst_rw", 32'(mrw0), 32'h1);
    chk("rst_size", 32'(msize0), 32'h2);
    chk("rst_uns", 32'(muns0), 32'h1);
    tick(1);
    reset = 1'b1;
    tick(1);

    // 1: fetch only, latency 1
    if_req0 = 1'b1; if_addr0 = 32'h100;
    push_g(0, 1'b0); push_r(0, 1'b0, 32'h13);
    tick(1);
    if_req0 = 1'b0;
    @(negedge clock);
    chk("t1_gnt", 32'(if_gnt0), 32'h1);
    chk("t1_addr", maddr0, 32'h100);
    chk("t1_busy", 32'(busy0), 32'h1);
    tick(1);
    @(negedge clock);
    chk("t1_rvalid", 32'(if_rvalid0), 32'h1);
    chk("t1_addr_idle", maddr0, 32'h0);
    chk("t1_busy_off", 32'(busy0), 32'h0);
    tick(2);

    // 2: simultaneous store and fetch: data first, fetch at RESP edge
    d_req0 = 1'b1; d_addr0 = 32'h200; d_wdata0 = 32'hDEAD_BEEF;
    d_rw0 = 1'b0; d_size0 = 2'd2; d_uns0 = 1'b0;
    if_req0 = 1'b1; if_addr0 = 32'h104;
    push_g(0, 1'b1); push_g(0, 1'b0);
    push_r(0, 1'b1, 32'h0); push_r(0, 1'b0, 32'h5A5A_0104);
    tick(1);
    d_req0 = 1'b0;
    @(negedge clock);
    chk("t2_rw", 32'(mrw0), 32'h0);
    chk("t2_din", mdin0, 32'hDEAD_BEEF);
    chk("t2_addr", maddr0, 32'h200);
    tick(1);
    @(negedge clock);
    chk("t2_drvalid", 32'(d_rvalid0), 32'h1);
    tick(1);
    if_req0 = 1'b0;
    @(negedge clock);
    chk("t2_if_gnt", 32'(if_gnt0), 32'h1);
    chk("t2_if_addr", maddr0, 32'h104);
    tick(3);

    // 3: starvation, data wins 4, fetch the 5th
    d_req0 = 1'b1; d_addr0 = 32'h300; d_rw0 = 1'b1; d_size0 = 2'd2;
    if_req0 = 1'b1; if_addr0 = 32'h108;
    for (int i = 0; i < 4; i++) push_g(0, 1'b1);
    push_g(0, 1'b0); push_g(0, 1'b1);
    for (int i = 0; i < 4; i++) push_r(0, 1'b1, 32'h5A5A_0300);
    push_r(0, 1'b0, 32'h5A5A_0108); push_r(0, 1'b1, 32'h5A5A_0300);
    tick(7);
    @(negedge clock);
    chk("t3_wait4", 32'(u0.wait_cnt_q), 32'h4);
    chk("t3_dgnt4", 32'(d_gnt0), 32'h1);
    tick(2);
    @(negedge clock);
    chk("t3_fetch5", 32'(if_gnt0), 32'h1);
    chk("t3_wait0", 32'(u0.wait_cnt_q), 32'h0);
    tick(2);
    d_req0 = 1'b0; if_req0 = 1'b0;
    tick(3);

    // 5: setup_write during ACCESS with both requests pending
    d_req0 = 1'b1; if_req0 = 1'b1; if_addr0 = 32'h10C;
    push_g(0, 1'b1); push_g(0, 1'b1); push_g(0, 1'b0);
    push_r(0, 1'b1, 32'h5A5A_0300); push_r(0, 1'b1, 32'h5A5A_0300);
    push_r(0, 1'b0, 32'h5A5A_010C);
    tick(1);
    setup_write = 1'b1;
    tick(1);
    @(negedge clock);
    chk("t5_rvalid", 32'(d_rvalid0), 32'h1);
    tick(2);
    @(negedge clock);
    chk("t5_busy_blk", 32'(busy0), 32'h0);
    chk("t5_wait_hold", 32'(u0.wait_cnt_q), 32'h1);
    setup_write = 1'b0;
    tick(1);
    d_req0 = 1'b0;
    @(negedge clock);
    chk("t5_dgnt", 32'(d_gnt0), 32'h1);
    tick(2);
    if_req0 = 1'b0;
    @(negedge clock);
    chk("t5_if_gnt", 32'(if_gnt0), 32'h1);
    tick(3);

    // 4: latency 3, byte unsigned load from 0x203
    d_req1 = 1'b1; d_addr1 = 32'h203; d_rw1 = 1'b1; d_size1 = 2'd0; d_uns1 = 1'b1;
    push_g(1, 1'b1); push_r(1, 1'b1, 32'hAB);
    tick(1);
    d_req1 = 1'b0;
    @(negedge clock);
    chk("t4_busy1", 32'(busy1), 32'h1);
    chk("t4_addr1", maddr1, 32'h203);
    chk("t4_size", 32'(msize1), 32'h0);
    chk("t4_uns", 32'(muns1), 32'h1);
    tick(2);
    @(negedge clock);
    chk("t4_busy3", 32'(busy1), 32'h1);
    chk("t4_addr3", maddr1, 32'h203);
    chk("t4_norv3", 32'(d_rvalid1), 32'h0);
    tick(1);
    @(negedge clock);
    chk("t4_rvalid4", 32'(d_rvalid1), 32'h1);
    chk("t4_busy4", 32'(busy1), 32'h0);
    chk("t4_addr4", maddr1, 32'h0);
    tick(2);

    // 6: reset mid-ACCESS discards the access
    d_req1 = 1'b1; d_addr1 = 32'h300; d_size1 = 2'd2; d_uns1 = 1'b0;
    if_req1 = 1'b1; if_addr1 = 32'h110;
    push_g(1, 1'b1);
    tick(2);
    @(negedge clock);
    chk("t6_wait1", 32'(u1.wait_cnt_q), 32'h1);
    reset = 1'b0;
    tick(1);
    @(negedge clock);
    chk("t6_busy", 32'(busy1), 32'h0);
    chk("t6_addr", maddr1, 32'h0);
    chk("t6_rw", 32'(mrw1), 32'h1);
    chk("t6_size", 32'(msize1), 32'h2);
    chk("t6_uns", 32'(muns1), 32'h1);
    chk("t6_wait0", 32'(u1.wait_cnt_q), 32'h0);
    d_req1 = 1'b0; if_req1 = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(6);

    chk("gnt_q_empty", 32'(gnt_q.size()), 32'h0);
    chk("rsp_q_empty", 32'(rsp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
